// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI responder with oversampled pins,
// a single-entry transmit buffer and a per-word receive strobe.
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              frame_err
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q, live_q;
    logic sclk_d, cs_d;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [CW-1:0]     bit_cnt;
    logic              last_bit, pending;
    logic [DATA_W-2:0] rx_shift;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_shift, tx_buf, tx_fill;
    logic              buf_full;
    logic do_rx, do_shift, do_load, word_done, abort;

    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign cs_s      = cs_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign last_bit  = (bit_cnt == CW'(DATA_W - 1));
    assign rx_next   = {rx_shift, mosi_s};
    assign tx_fill   = buf_full ? tx_buf : (tx_load ? tx_data : '0);
    assign busy      = (state == SHIFT);
    assign miso      = busy & tx_shift[DATA_W-1];
    assign tx_ready  = ~buf_full;

    // Pin synchronizers, edge history, and a flush chain so stale
    // reset levels are never mistaken for a real idle cs_n.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
            live_q <= '0;
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            live_q <= {live_q[SYNC_STAGES-2:0], 1'b1};
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_IDLE;
        else     state <= state_n;
    end

    // Next state and per-cycle datapath controls.
    always_comb begin
        state_n   = state;
        do_rx     = 1'b0;
        do_shift  = 1'b0;
        do_load   = 1'b0;
        word_done = 1'b0;
        abort     = 1'b0;
        unique case (state)
            WAIT_IDLE: begin
                if (live_q[SYNC_STAGES-1] && cs_s) state_n = IDLE;
            end
            IDLE: begin
                if (cs_fall) begin
                    state_n = SHIFT;
                    do_load = 1'b1;
                end
            end
            SHIFT: begin
                do_rx     = sclk_rise;
                word_done = sclk_rise & last_bit;
                if (cs_rise) begin
                    state_n = IDLE;
                    abort   = (bit_cnt != '0) && !word_done;
                end else if (sclk_fall) begin
                    do_load  = pending;
                    do_shift = ~pending;
                end
            end
            default: state_n = WAIT_IDLE;
        endcase
    end

    // Receive path: bit counter, rx shifter and completed-word strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            pending   <= 1'b0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= word_done;
            frame_err <= abort;
            if (state != SHIFT) begin
                bit_cnt <= '0;
                pending <= 1'b0;
            end else if (do_rx) begin
                rx_shift <= rx_next[DATA_W-2:0];
                if (word_done) begin
                    rx_data <= rx_next;
                    bit_cnt <= '0;
                    pending <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end else if (do_load) begin
                pending <= 1'b0;
            end
        end
    end

    // Transmit path: shifter plus single-entry buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift <= '0;
            tx_buf   <= '0;
            buf_full <= 1'b0;
        end else begin
            if (do_load)
                tx_shift <= tx_fill;
            else if (do_shift)
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            if (do_load && buf_full) begin
                buf_full <= 1'b0;
            end else if (tx_load && !buf_full && !do_load) begin
                tx_buf   <= tx_data;
                buf_full <= 1'b1;
            end
        end
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder (slave) for the team's SPI master. Operates in SPI mode 0 (CPOL=0, CPHA=0), MSB first. SCLK, CS_N and MOSI are oversampled into the system clock domain; one DATA_W-bit word is received on MOSI while one word is returned on MISO. Received words go to the local fabric with a one-cycle valid strobe. Transmit words are supplied through a single-entry buffer with a ready/load handshake.

## Interface
- DATA_W, 8, word length in bits (≥2)
- SYNC_STAGES, 2, synchronizer flops on sclk/cs_n/mosi (≥2)

- clk  in  1  system clock; f_clk ≥ 8 × f_sclk
- rst  in  1  asynchronous, active-high reset
- sclk  in  1  SPI clock from master, asynchronous to clk
- cs_n  in  1  chip select, active low, asynchronous
- mosi  in  1  master-out data
- miso  out  1  slave-out data; 0 whenever not selected
- tx_data  in  DATA_W  next word to transmit
- tx_load  in  1  write tx_data into the buffer; honoured only when tx_ready=1
- tx_ready  out  1  transmit buffer empty
- rx_data  out  DATA_W  last complete received word; held until the next word completes
- rx_valid  out  1  one-cycle strobe: rx_data updated
- busy  out  1  state is SHIFT
- frame_err  out  1  one-cycle strobe: cs_n deasserted mid-word

## Operation
- Synchronizers reset to idle levels: sclk=0, cs_n=1, mosi=0. Edge detection compares the last sync stage with one extra history flop.
- State IDLE: waits for the synchronized cs_n falling edge, then moves to SHIFT.
  - bit_cnt is set to 0.
  - The tx shift register is loaded from the buffer if full, else with all zeros.
  - On load, the buffer empties and tx_ready=1.
  - miso = shift-register MSB.
- State SHIFT:
  - On sclk rise: rx_shift = {rx_shift[DATA_W-2:0], mosi_sync} and bit_cnt++.
  - On sclk fall: tx shifts left and miso = new MSB. The fall that follows the final rise of a word does not shift; it loads the next word instead.
  - On the DATA_W-th rise: rx_data = assembled word, rx_valid pulses, and bit_cnt = 0.
  - On the next fall: tx reloads from the buffer (or zeros). This supports back-to-back words under one cs_n.
  - cs_n rise with bit_cnt=0: go to IDLE, no error.
  - cs_n rise with bit_cnt≠0: discard the partial word, pulse frame_err, go to IDLE. rx_data is unchanged.
- State WAIT_IDLE: entered out of reset. Stays until synchronized cs_n=1, then goes to IDLE. This prevents joining a frame mid-way.
- TX buffer:
  - tx_load with tx_ready=1 captures tx_data and drops tx_ready.
  - tx_load with tx_ready=0 is ignored; buffer contents are unchanged.
  - If tx_load and a shift-register load occur in the same cycle with the buffer empty, tx_data goes straight into the shift register and tx_ready stays 1.
- miso = 0 in IDLE and WAIT_IDLE.

## Timing
- Reset values:
  - miso=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, frame_err=0.
  - State = WAIT_IDLE, bit_cnt=0, shift registers 0.
  - Synchronizers at idle levels.
- Input-to-detect latency: SYNC_STAGES+1 clk cycles from the first clk edge sampling a pin change.
- rx_valid rises SYNC_STAGES+1 cycles after clk first samples the DATA_W-th sclk high. It is high for exactly 1 cycle.
- miso updates SYNC_STAGES+1 cycles after the sclk fall is sampled. This is ≤ half an SCLK period given the f_clk ratio.
- Simultaneous events:
  - Final rise and cs_n rise detected in the same cycle: the word completes (rx_valid=1), frame_err=0, next state IDLE.
  - cs_n fall and rise within a single clk detect window: ignored.
- Reset mid-frame: everything is abandoned immediately. No rx_valid or frame_err is generated.

## Test plan
- Reset sequence: reset released with cs_n=1 -> tx_ready=1, miso=0, busy=0; state reaches IDLE after SYNC_STAGES+1 cycles.
- Single word exchange: load tx_data=8'hA5, master sends 8'h3C -> rx_data=8'h3C with a single rx_valid pulse; master captures 8'hA5; tx_ready=1 from frame start.
- Back-to-back words: load 8'h12, start frame, load 8'h34 during word 1, then 16 clocks under one cs_n, master sending 8'hC3, 8'h5A -> two rx_valid pulses with rx_data 8'hC3 then 8'h5A; miso returns 8'h12, 8'h34.
- Aborted frame: cs_n rises after 5 bits -> frame_err pulses once; no rx_valid; rx_data keeps its prior value; the next full frame receives correctly.
- Empty buffer, plus tx_load while tx_ready=0:
  - Frame with no load -> miso shifts out 8'h00.
  - Load 8'h11, then tx_load 8'h22 while tx_ready=0 -> transmitted word is 8'h11.
- Reset mid-frame with cs_n held low: rst pulse at bit 4 -> no rx_valid or frame_err. The slave ignores the remaining bits until cs_n goes high, and the next frame works.
